// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to a small register window feed
// a byte FIFO that a serialiser drains onto tx. Reads are combinational for the bus mux.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  logic        sel_status, wr_data, wr_status;
  logic        full, empty, busy, push, pop, baud_done;
  logic [31:0] count_ext;
  logic [3:0]  count_sat;
  logic        unused_bits;

  // Decode: address bits [1:0] are don't-care, bit 2 selects TXDATA/STATUS.
  assign hit        = (address_to_mem[31:3] == BASE_ADDR[31:3]);
  assign sel_status = address_to_mem[2];
  assign wr_data    = write_enable & hit & ~sel_status;
  assign wr_status  = write_enable & hit & sel_status;
  assign unused_bits = ^{address_to_mem[1:0], data_to_mem[31:8]};

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign busy  = (state_reg != IDLE);
  // Full is judged before the edge, so a same-cycle pop never rescues a push.
  assign push  = wr_data & ~full;
  assign pop   = (state_reg == IDLE) & ~empty;

  assign count_ext = 32'(count_reg);
  assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    read_data = '0;
    if (hit && sel_status)
      read_data = {24'b0, count_sat, overflow_reg, busy, empty, full};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)
        count_reg <= count_reg + CW'(1);
      else if (pop && !push)
        count_reg <= count_reg - CW'(1);
      if (wr_data && full)
        overflow_reg <= 1'b1;
      else if (wr_status && data_to_mem[3])
        overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= data_to_mem[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  assign baud_done = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + BW'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = 1'b1;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (!empty) begin
          state_next = START;
          shift_next = mem[rd_ptr_reg];
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7)
            state_next = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_next = IDLE;
          baud_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    // tx is registered from the next state so the line never glitches on decode.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx = tx_reg;

endmodule
